// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I pipeline control blocks: forwarding
// select encodings and the hazard-controller wait-state encoding.
package rv32i_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    HZ_IDLE     = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  // A producer only counts when it writes, targets a real register (x0 is
  // hardwired zero) and names the consumer's source.
  function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forwarding select for one Execute-stage source operand.
// The Memory-stage result is newer than the Writeback result, so it wins.
module fwd_sel
  import rv32i_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       reg_write_m,
  input  logic [4:0] rd_m,
  input  logic       reg_write_w,
  input  logic [4:0] rd_w,
  output logic [1:0] fwd
);

  // Pick the youngest in-flight producer of rs, else the register file.
  always_comb begin
    fwd = FWD_RF;
    if (reg_match(reg_write_m, rd_m, rs))
      fwd = FWD_MEM;
    else if (reg_match(reg_write_w, rd_w, rs))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   HZ_IDLE     | no data-memory access outstanding beyond the current cycle
//   HZ_MEM_WAIT | Memory-stage access waiting for dmem_ack (bounded timeout)
//
// Stall/flush/forward outputs are combinational from state plus inputs so the
// datapath sees them in the same cycle. Everything is forced to 0 while rst is
// low, which also drops dmem_req the moment reset asserts mid-wait.
module pipeline_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             dmem_ack,
  input  logic             imem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             StallM,
  output logic             FlushW,
  output logic             dmem_req,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  hz_state_e   state;
  logic [CW-1:0] cnt;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        timeout;
  logic        mem_stall;
  logic        lw_stall;

  fwd_sel u_fwd_a (
    .rs          (Rs1E),
    .reg_write_m (RegWriteM),
    .rd_m        (RdM),
    .reg_write_w (RegWriteW),
    .rd_w        (RdW),
    .fwd         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs          (Rs2E),
    .reg_write_m (RegWriteM),
    .rd_m        (RdM),
    .reg_write_w (RegWriteW),
    .rd_w        (RdW),
    .fwd         (fwd_b)
  );

  assign timeout  = (state == HZ_MEM_WAIT) && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign lw_stall = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = (state == HZ_IDLE) ? (MemAccessM && !dmem_ack)
                                        : (!dmem_ack && !timeout);

  // Wait-state FSM; cnt counts MEM_WAIT cycles from zero on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        HZ_IDLE: begin
          if (MemAccessM && !dmem_ack) begin
            state <= HZ_MEM_WAIT;
            cnt   <= '0;
          end
        end
        HZ_MEM_WAIT: begin
          if (dmem_ack || timeout)
            state <= HZ_IDLE;
          else
            cnt <= cnt + CW'(1);
        end
        default: begin
          state <= HZ_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // One priority rule per cycle: memory wait, branch, load-use, fetch wait.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    StallE    = 1'b0;
    FlushE    = 1'b0;
    StallM    = 1'b0;
    FlushW    = 1'b0;
    dmem_req  = 1'b0;
    dmem_err  = 1'b0;
    if (rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      dmem_req  = ((state == HZ_IDLE) && MemAccessM) || (state == HZ_MEM_WAIT);
      // Ack arriving on the timeout cycle is a normal completion.
      dmem_err  = timeout && !dmem_ack;
      if (mem_stall) begin
        // Whole front of the pipe freezes; a taken branch waits in E.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (!imem_ready) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end
    end
  end

  // Saturating count of PC-hold cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (StallF && !(&stall_cycles))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with short timeout and narrow
// perf counter so timeout and saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM;
  logic          dmem_ack, imem_ready;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW;
  logic          dmem_req, dmem_err;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // {StallF,StallD,FlushD,StallE,FlushE,StallM,FlushW,dmem_req,dmem_err}
  wire [8:0] ctl = {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW,
                    dmem_req, dmem_err};

  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_LWS    = 9'b110010000;
  localparam logic [8:0] C_BR     = 9'b001010000;
  localparam logic [8:0] C_FETCH  = 9'b101000000;
  localparam logic [8:0] C_MEMSTL = 9'b110101110;
  localparam logic [8:0] C_REQ    = 9'b000000010;
  localparam logic [8:0] C_BRREQ  = 9'b001010010;
  localparam logic [8:0] C_ERR    = 9'b000000011;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .dmem_ack(dmem_ack),
    .imem_ready(imem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallE(StallE),
    .FlushE(FlushE), .StallM(StallM), .FlushW(FlushW),
    .dmem_req(dmem_req), .dmem_err(dmem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0; MemAccessM = 0;
    dmem_ack = 0; imem_ready = 1;
  endtask

  // Advance one clock; inputs are then driven mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    quiet();
    // Hostile inputs under reset: everything must stay 0.
    MemAccessM = 1; LoadE = 1; RdE = 3; Rs1D = 3; imem_ready = 0;
    RegWriteM = 1; RdM = 4; Rs1E = 4;
    step(); step();
    chk("rst_ctl", 32'(ctl), 32'(C_NONE));
    chk("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'h0);
    chk("rst_cnt", 32'(stall_cycles), 32'h0);

    quiet();
    #1 rst = 1'b1;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_NONE));

    // Forwarding: Memory beats Writeback, x0 never forwards.
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
    chk("fwd_mem_wins", 32'(ForwardAE), 32'h2);
    chk("fwd_b_none", 32'(ForwardBE), 32'h0);
    RegWriteM = 0; Rs2E = 5; #1;
    chk("fwd_wb_a", 32'(ForwardAE), 32'h1);
    chk("fwd_wb_b", 32'(ForwardBE), 32'h1);
    RegWriteM = 1; RdM = 3; #1;
    chk("fwd_mem_other", 32'(ForwardAE), 32'h1);
    Rs2E = 3; #1;
    chk("fwd_mem_b", 32'(ForwardBE), 32'h2);
    quiet(); RdM = 0; RegWriteM = 1; Rs1E = 0; RdW = 0; RegWriteW = 1; #1;
    chk("fwd_x0", 32'(ForwardAE), 32'h0);

    // Load-use: one bubble, then release.
    quiet(); LoadE = 1; RdE = 7; Rs2D = 7; #1;
    chk("lwstall_ctl", 32'(ctl), 32'(C_LWS));
    step();
    quiet(); Rs2D = 7; #1;
    chk("lwstall_release", 32'(ctl), 32'(C_NONE));
    chk("lwstall_cnt", 32'(stall_cycles), 32'd1);
    quiet(); LoadE = 1; RdE = 0; Rs1D = 0; Rs2D = 0; #1;
    chk("lwstall_x0", 32'(ctl), 32'(C_NONE));

    // Branch overrides load-use and fetch wait.
    quiet(); LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; imem_ready = 0; #1;
    chk("branch_ctl", 32'(ctl), 32'(C_BR));

    // Fetch wait.
    quiet(); imem_ready = 0; #1;
    chk("fetch_ctl", 32'(ctl), 32'(C_FETCH));
    step();
    quiet(); #1;
    chk("fetch_cnt", 32'(stall_cycles), 32'd2);

    // Memory wait, ack in cycle 3, with a pending taken branch held in E.
    MemAccessM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("memwait_c%0d", i), 32'(ctl), 32'(C_MEMSTL));
      step();
    end
    dmem_ack = 1; #1;
    chk("memwait_ack", 32'(ctl), 32'(C_BRREQ));
    step();
    quiet(); #1;
    chk("memwait_idle", 32'(ctl), 32'(C_NONE));
    chk("memwait_cnt", 32'(stall_cycles), 32'd5);

    // Immediate ack in IDLE: no stall, no wait state.
    MemAccessM = 1; dmem_ack = 1; #1;
    chk("fastack_ctl", 32'(ctl), 32'(C_REQ));
    step();
    quiet(); #1;
    chk("fastack_idle", 32'(ctl), 32'(C_NONE));

    // Timeout without ack: err pulses on the 4th MEM_WAIT cycle only.
    MemAccessM = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("to_wait%0d", i), 32'(ctl), 32'(C_MEMSTL));
      step();
    end
    chk("to_err", 32'(ctl), 32'(C_ERR));
    step();
    quiet(); #1;
    chk("to_idle", 32'(ctl), 32'(C_NONE));
    chk("to_cnt", 32'(stall_cycles), 32'd9);

    // Timeout coinciding with ack: completion, no error.
    MemAccessM = 1;
    for (int i = 0; i < 4; i++) step();
    dmem_ack = 1; #1;
    chk("to_ack_noerr", 32'(ctl), 32'(C_REQ));
    step();
    quiet(); #1;
    chk("to_ack_idle", 32'(ctl), 32'(C_NONE));
    chk("to_ack_cnt", 32'(stall_cycles), 32'd13);

    // Saturation at all-ones.
    imem_ready = 0;
    for (int i = 0; i < 5; i++) step();
    quiet(); #1;
    chk("sat_cnt", 32'(stall_cycles), 32'd15);

    // Reset in the middle of a wait.
    MemAccessM = 1;
    step(); step();
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst = 1'b0; #1;
    chk("midrst_ctl", 32'(ctl), 32'(C_NONE));
    chk("midrst_cnt", 32'(stall_cycles), 32'd0);
    step();
    MemAccessM = 0;
    rst = 1'b1; #1;
    chk("postrst_idle", 32'(ctl), 32'(C_NONE));
    MemAccessM = 1; #1;
    chk("postrst_stall", 32'(ctl), 32'(C_MEMSTL));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
